// File: rtl/run_tx_pkg.sv
// Shared types and defaults for the run_tx serial run transmitter.
package run_tx_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_GAP  = 2'b10
    } state_t;

    localparam int unsigned GAP_DEFAULT   = 1;
    localparam int unsigned LEN_W_DEFAULT = 4;

endpackage

// File: rtl/run_tx_if.sv
// Sequencer <-> run_tx handshake and serial line bundle.
// The abort signal exists only when RUN_TX_ABORT_EN is defined.
interface run_tx_if
    import run_tx_pkg::*;
#(
    parameter int unsigned LEN_W = LEN_W_DEFAULT
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             ready;
    logic             q;
    logic             done;
`ifdef RUN_TX_ABORT_EN
    logic             abort;

    modport master (output start, len, abort, input  ready, q, done);
    modport slave  (input  start, len, abort, output ready, q, done);
`else
    modport master (output start, len, input  ready, q, done);
    modport slave  (input  start, len, output ready, q, done);
`endif
endinterface

// File: rtl/run_tx_cnt.sv
// Loadable down-counter with zero flag, shared by the run and gap phases.
module run_tx_cnt #(
    parameter int unsigned LEN_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             dec,
    input  logic [LEN_W-1:0] d,
    output logic             zero
);
    logic [LEN_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= d;
        end else if (dec) begin
            cnt <= cnt - LEN_W'(1);
        end
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/run_tx.sv
// Serial run transmitter: q high for len cycles, low for GAP cycles, then done.
// Optional abort input enabled by RUN_TX_ABORT_EN. GAP legal range 1..15.
module run_tx
    import run_tx_pkg::*;
#(
    parameter int unsigned LEN_W = LEN_W_DEFAULT,
    parameter int unsigned GAP   = GAP_DEFAULT
) (
    input  logic     clk,
    input  logic     reset,
    run_tx_if.slave  bus
);
    localparam logic [LEN_W-1:0] GAP_LOAD = LEN_W'(GAP - 1);

    state_t           state;
    logic             q_r;
    logic             ready_r;
    logic             done_r;
    logic             accept;
    logic             abort_req;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_zero;
    logic [LEN_W-1:0] cnt_d;

    assign accept = (state == S_IDLE) && bus.start && (bus.len != '0);

`ifdef RUN_TX_ABORT_EN
    assign abort_req = bus.abort && ((state == S_RUN) || (state == S_GAP));
`else
    assign abort_req = 1'b0;
`endif

    // One counter serves both phases: loaded with len-1 on accept, GAP-1 on run end.
    always_comb begin
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_d    = bus.len - LEN_W'(1);
        case (state)
            S_IDLE: cnt_load = accept;
            S_RUN: begin
                if (cnt_zero) begin
                    cnt_load = 1'b1;
                    cnt_d    = GAP_LOAD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            S_GAP:   cnt_dec = !cnt_zero;
            default: ;
        endcase
    end

    run_tx_cnt #(.LEN_W(LEN_W)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .load  (cnt_load),
        .dec   (cnt_dec),
        .d     (cnt_d),
        .zero  (cnt_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            q_r     <= 1'b0;
            ready_r <= 1'b1;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (abort_req) begin
                state   <= S_IDLE;
                q_r     <= 1'b0;
                ready_r <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (accept) begin
                            state   <= S_RUN;
                            q_r     <= 1'b1;
                            ready_r <= 1'b0;
                        end
                    end
                    S_RUN: begin
                        if (cnt_zero) begin
                            state <= S_GAP;
                            q_r   <= 1'b0;
                        end
                    end
                    S_GAP: begin
                        if (cnt_zero) begin
                            state   <= S_IDLE;
                            ready_r <= 1'b1;
                            done_r  <= 1'b1;
                        end
                    end
                    default: begin
                        state   <= S_IDLE;
                        q_r     <= 1'b0;
                        ready_r <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.q     = q_r;
    assign bus.ready = ready_r;
    assign bus.done  = done_r;
endmodule

// File: tb/tb_run_tx.sv
// Scoreboard bench for run_tx: expected {q,ready,done} per cycle queued at stimulus time.
module tb_run_tx;
    import run_tx_pkg::*;

    localparam int unsigned LW = LEN_W_DEFAULT;
    localparam int unsigned GP = GAP_DEFAULT;

    localparam logic [2:0] V_IDLE = 3'b010;
    localparam logic [2:0] V_RUN  = 3'b100;
    localparam logic [2:0] V_GAP  = 3'b000;
    localparam logic [2:0] V_DONE = 3'b011;

    logic clk = 1'b0;
    logic reset;
    int   n_total = 0;
    int   n_bad   = 0;
    logic [2:0] exp_q[$];

    always #5 clk = ~clk;

    run_tx_if #(.LEN_W(LW)) bus ();

    run_tx #(.LEN_W(LW), .GAP(GP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: q/ready/done got=%b want=%b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_n(input int n, input logic [2:0] v);
        for (int i = 0; i < n; i++) exp_q.push_back(v);
    endtask

    task automatic push_run(input int l);
        push_n(l, V_RUN);
        push_n(GP, V_GAP);
        push_n(1, V_DONE);
    endtask

    task automatic tick(input string tag);
        logic [2:0] e;
        @(posedge clk);
        #1;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 3'bzzz;
        chk(tag, {bus.q, bus.ready, bus.done}, e);
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() > 0) tick(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.len   = '0;
`ifdef RUN_TX_ABORT_EN
        bus.abort = 1'b0;
`endif
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("in_reset", {bus.q, bus.ready, bus.done}, V_IDLE);
        end
        reset = 1'b1;
        push_n(2, V_IDLE);
        drain("post_reset");

        // single run len=3; len change mid-run must be ignored
        bus.start = 1'b1;
        bus.len   = 4'd3;
        push_run(3);
        tick("run3");
        bus.start = 1'b0;
        bus.len   = 4'd9;
        drain("run3");
        push_n(2, V_IDLE);
        drain("run3_after");

        // len=0 request is a no-op
        bus.start = 1'b1;
        bus.len   = '0;
        push_n(4, V_IDLE);
        drain("len0");
        bus.start = 1'b0;

        // back-to-back with start held: restart on the edge after done
        bus.start = 1'b1;
        bus.len   = 4'd2;
        push_run(2);
        push_run(2);
        push_run(2);
        drain("b2b");
        bus.start = 1'b0;
        push_n(2, V_IDLE);
        drain("b2b_after");

        // maximum run length
        bus.start = 1'b1;
        bus.len   = 4'd15;
        push_run(15);
        tick("run15");
        bus.start = 1'b0;
        bus.len   = 4'd1;
        drain("run15");
        push_n(1, V_IDLE);
        drain("run15_after");

        // shortest run
        bus.start = 1'b1;
        bus.len   = 4'd1;
        push_run(1);
        tick("run1");
        bus.start = 1'b0;
        drain("run1");
        push_n(1, V_IDLE);
        drain("run1_after");

        // reset asserted during cycle t+2 of a len=5 run
        bus.start = 1'b1;
        bus.len   = 4'd5;
        push_n(2, V_RUN);
        tick("rst_mid");
        bus.start = 1'b0;
        drain("rst_mid");
        #2;
        reset = 1'b0;
        #1;
        chk("rst_async", {bus.q, bus.ready, bus.done}, V_IDLE);
        @(posedge clk);
        #1;
        reset = 1'b1;
        push_n(8, V_IDLE);
        drain("rst_no_done");

`ifdef RUN_TX_ABORT_EN
        // abort at t+3 of len=6
        bus.start = 1'b1;
        bus.len   = 4'd6;
        push_n(3, V_RUN);
        push_n(3, V_IDLE);
        tick("abort6");
        bus.start = 1'b0;
        tick("abort6");
        tick("abort6");
        bus.abort = 1'b1;
        tick("abort6");
        bus.abort = 1'b0;
        drain("abort6");

        // abort wins over run expiry
        bus.start = 1'b1;
        bus.len   = 4'd1;
        push_n(1, V_RUN);
        push_n(2, V_IDLE);
        tick("abort_prio");
        bus.start = 1'b0;
        bus.abort = 1'b1;
        tick("abort_prio");
        bus.abort = 1'b0;
        drain("abort_prio");

        // abort in IDLE is ignored
        bus.abort = 1'b1;
        push_n(2, V_IDLE);
        drain("abort_idle");
        bus.abort = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
